// File: rtl/program_loader_pkg.sv
// Shared definitions for the MiniAlu program loader: FSM states, sync marker
// default and the instruction word layout.
package program_loader_pkg;

    localparam int INSTR_W  = 28;
    localparam int OPCODE_W = 4;
    localparam int FIELD_W  = 8;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [FIELD_W-1:0]  dest;
        logic [FIELD_W-1:0]  src1;
        logic [FIELD_W-1:0]  src0;
    } instr_t;

    // Byte 0 of an instruction carries only the opcode; its upper bits must be clear.
    function automatic logic opcode_byte_ok(input logic [FIELD_W-1:0] b);
        return b[FIELD_W-1:OPCODE_W] == '0;
    endfunction

endpackage

// File: rtl/instr_byte_assembler.sv
// Collects four stream bytes (MSB first) into one instruction word and flags
// a malformed opcode byte or a completed word in the cycle the byte arrives.
module instr_byte_assembler
    import program_loader_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clear,
    input  logic               load,
    input  logic [FIELD_W-1:0] byte_in,
    output instr_t             word,
    output logic               word_done,
    output logic               nibble_bad
);

    localparam int ACC_W = OPCODE_W + 2 * FIELD_W;

    logic [1:0]       index;
    logic [ACC_W-1:0] acc;

    assign nibble_bad = load && (index == 2'd0) && !opcode_byte_ok(byte_in);
    assign word_done  = load && (index == 2'd3);
    // The final byte is used straight from the input so the word is ready in its arrival cycle.
    assign word       = instr_t'({acc, byte_in});

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            index <= 2'd0;
            acc   <= '0;
        end else if (clear) begin
            index <= 2'd0;
            acc   <= '0;
        end else if (load && !nibble_bad) begin
            index <= index + 2'd1;
            if (index == 2'd0)
                acc <= ACC_W'(byte_in);
            else
                acc <= {acc[ACC_W-FIELD_W-1:0], byte_in};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a framed program over a valid/ready byte link, writes the decoded
// instructions into instruction RAM and holds the CPU in reset until verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int               ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]       SYNC_BYTE = DEFAULT_SYNC
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iByteValid,
    input  logic [7:0]         iByte,
    output logic               oByteReady,
    output logic               oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddress,
    output logic [INSTR_W-1:0] oWriteData,
    output logic               oCpuReset,
    output logic               oDone,
    output logic               oError
);

    state_t     state;
    logic [7:0] count;
    logic [7:0] instr_idx;
    logic [7:0] chk;

    logic   accept;
    instr_t word;
    logic   word_done;
    logic   nibble_bad;

    assign accept = iByteValid && oByteReady;

    instr_byte_assembler u_assembler (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (accept && (state == ST_COUNT)),
        .load       (accept && (state == ST_DATA)),
        .byte_in    (iByte),
        .word       (word),
        .word_done  (word_done),
        .nibble_bad (nibble_bad)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= ST_IDLE;
            count         <= 8'd0;
            instr_idx     <= 8'd0;
            chk           <= 8'd0;
            oByteReady    <= 1'b1;
            oWriteEnable  <= 1'b0;
            oWriteAddress <= BASE_ADDR;
            oWriteData    <= '0;
            oCpuReset     <= 1'b1;
            oDone         <= 1'b0;
            oError        <= 1'b0;
        end else begin
            oWriteEnable <= 1'b0;
            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        if (iByte == SYNC_BYTE)
                            state <= ST_COUNT;
                    end
                    ST_COUNT: begin
                        count     <= iByte;
                        chk       <= iByte;
                        instr_idx <= 8'd0;
                        state     <= (iByte == 8'd0) ? ST_CHECK : ST_DATA;
                    end
                    ST_DATA: begin
                        chk <= chk ^ iByte;
                        if (nibble_bad) begin
                            state     <= ST_ERROR;
                            oError    <= 1'b1;
                            oCpuReset <= 1'b1;
                        end else if (word_done) begin
                            oWriteEnable  <= 1'b1;
                            oWriteAddress <= BASE_ADDR + ADDR_W'(instr_idx);
                            oWriteData    <= word;
                            instr_idx     <= instr_idx + 8'd1;
                            if (instr_idx + 8'd1 == count)
                                state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (iByte == chk) begin
                            state      <= ST_DONE;
                            oDone      <= 1'b1;
                            oCpuReset  <= 1'b0;
                            oByteReady <= 1'b0;
                        end else begin
                            state  <= ST_ERROR;
                            oError <= 1'b1;
                        end
                    end
                    ST_ERROR: begin
                        // A fresh sync restarts a frame from the base address.
                        if (iByte == SYNC_BYTE) begin
                            state         <= ST_COUNT;
                            oError        <= 1'b0;
                            oWriteAddress <= BASE_ADDR;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
